// File: rtl/load_store_sequencer.sv
// load_store_sequencer
//   Sequences one load or store at a time from decode onto a simple
//   request/ack data bus. Generates word-aligned addresses, byte-lane
//   enables and lane-replicated store data. Extracts and sign/zero-extends
//   load data, stalls the pipeline while an access is outstanding, and
//   aborts an access that sees no ack within TIMEOUT_CYCLES bus cycles.
//
//   Optional feature: define MISALIGN_TRAP_EN to trap misaligned HALF/WORD
//   accesses (IDLE->ERR, no bus request). Without it, the low address bits
//   are simply truncated.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   mem_read_in         : load request (wins if mem_write_in is also set)
//   mem_write_in        : store request
//   mem_width_in[3:0]   : WORD 4'b0000, HALF 4'b0101, BYTE 4'b1010 (others = WORD)
//   mem_zero_extend_in  : 1 = zero-extend load, 0 = sign-extend
//   addr_in[31:0]       : effective address
//   wdata_in[31:0]      : store data
//   bus_req_out         : bus request (high for the whole bus phase)
//   bus_we_out          : bus write enable
//   bus_addr_out[31:0]  : word-aligned bus address
//   bus_be_out[3:0]     : byte-lane enables
//   bus_wdata_out[31:0] : lane-replicated store data
//   bus_ack_in          : bus completion, bus_rdata_in valid same cycle
//   bus_rdata_in[31:0]  : raw read word
//   stall_out           : pipeline freeze while an access is outstanding
//   rdata_out[31:0]     : extended load result, held until the next read
//   done_out            : one-cycle completion pulse
//   err_out             : one-cycle timeout/misalignment pulse
module load_store_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [3:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [3:0]  bus_be_out,
  output logic [31:0] bus_wdata_out,
  input  logic        bus_ack_in,
  input  logic [31:0] bus_rdata_in,
  output logic        stall_out,
  output logic [31:0] rdata_out,
  output logic        done_out,
  output logic        err_out
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] WCODE_HALF = 4'b0101;
  localparam logic [3:0] WCODE_BYTE = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    W_WORD,
    W_HALF,
    W_BYTE
  } wkind_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;

  // Access attributes latched on the IDLE->BUS edge.
  wkind_t        r_kind;
  logic          r_zext;
  logic          r_we;
  logic [1:0]    r_off;
  logic [3:0]    r_be;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;

  // Request decode (combinational, IDLE only).
  wkind_t        w_kind;
  logic          w_req;
  logic          w_is_write;
  logic          w_trap;
  logic [1:0]    w_off;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_latch;
  logic          w_cnt_last;

  // Load extraction.
  logic [31:0]   w_shift;
  logic [31:0]   w_load;

  always_comb begin
    w_kind = W_WORD;
    if (mem_width_in == WCODE_HALF) begin
      w_kind = W_HALF;
    end else if (mem_width_in == WCODE_BYTE) begin
      w_kind = W_BYTE;
    end
  end

  assign w_req      = mem_read_in | mem_write_in;
  assign w_is_write = mem_write_in & ~mem_read_in;

  always_comb begin
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = wdata_in;
    unique case (w_kind)
      W_BYTE: begin
        w_off   = addr_in[1:0];
        w_be    = 4'b0001 << addr_in[1:0];
        w_wdata = {4{wdata_in[7:0]}};
      end
      W_HALF: begin
        w_off   = {addr_in[1], 1'b0};
        w_be    = 4'b0011 << {addr_in[1], 1'b0};
        w_wdata = {2{wdata_in[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = wdata_in;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign w_trap = ((w_kind == W_HALF) && addr_in[0]) ||
                  ((w_kind == W_WORD) && (addr_in[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_trap) begin
            w_state_next = S_ERR;
          end else begin
            w_state_next = S_BUS;
            w_latch      = 1'b1;
          end
        end
      end
      S_BUS: begin
        if (bus_ack_in) begin
          w_state_next = S_DONE;
        end else if (w_cnt_last) begin
          w_state_next = S_ERR;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend.
  assign w_shift = bus_rdata_in >> {r_off, 3'b000};

  always_comb begin
    w_load = w_shift;
    unique case (r_kind)
      W_BYTE:  w_load = r_zext ? {24'h0, w_shift[7:0]}
                               : {{24{w_shift[7]}}, w_shift[7:0]};
      W_HALF:  w_load = r_zext ? {16'h0, w_shift[15:0]}
                               : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_load = bus_rdata_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_kind  <= W_WORD;
      r_zext  <= 1'b0;
      r_we    <= 1'b0;
      r_off   <= 2'b00;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_cnt   <= '0;
        r_kind  <= w_kind;
        r_zext  <= mem_zero_extend_in;
        r_we    <= w_is_write;
        r_off   <= w_off;
        r_be    <= w_be;
        r_addr  <= {addr_in[31:2], 2'b00};
        r_wdata <= w_wdata;
      end else if ((r_state == S_BUS) && !bus_ack_in && !w_cnt_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Only reads update the result; it holds across stores and errors.
      if ((r_state == S_BUS) && bus_ack_in && !r_we) begin
        r_rdata <= w_load;
      end
    end
  end

  assign bus_req_out   = (r_state == S_BUS);
  assign bus_we_out    = (r_state == S_BUS) & r_we;
  assign bus_be_out    = (r_state == S_BUS) ? r_be : 4'b0000;
  assign bus_addr_out  = r_addr;
  assign bus_wdata_out = r_wdata;
  assign rdata_out     = r_rdata;
  assign done_out      = (r_state == S_DONE);
  assign err_out       = (r_state == S_ERR);
  assign stall_out     = ((r_state == S_IDLE) && w_req && !w_trap) ||
                         (r_state == S_BUS);

endmodule

// File: tb/tb_load_store_sequencer.sv
module tb_load_store_sequencer;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [3:0]  mem_width_in;
  logic        mem_zero_extend_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        bus_req_out;
  logic        bus_we_out;
  logic [31:0] bus_addr_out;
  logic [3:0]  bus_be_out;
  logic [31:0] bus_wdata_out;
  logic        bus_ack_in;
  logic [31:0] bus_rdata_in;
  logic        stall_out;
  logic [31:0] rdata_out;
  logic        done_out;
  logic        err_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata;

  load_store_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .mem_width_in       (mem_width_in),
    .mem_zero_extend_in (mem_zero_extend_in),
    .addr_in            (addr_in),
    .wdata_in           (wdata_in),
    .bus_req_out        (bus_req_out),
    .bus_we_out         (bus_we_out),
    .bus_addr_out       (bus_addr_out),
    .bus_be_out         (bus_be_out),
    .bus_wdata_out      (bus_wdata_out),
    .bus_ack_in         (bus_ack_in),
    .bus_rdata_in       (bus_rdata_in),
    .stall_out          (stall_out),
    .rdata_out          (rdata_out),
    .done_out           (done_out),
    .err_out            (err_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

  // Runs one access. ack_delay = index of the bus cycle carrying the ack;
  // ack_delay >= TO means the bus never answers.
  task automatic run_access(input string nm, input logic rd, input logic wr,
                            input logic [3:0] wc, input logic zx,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int ack_delay, input logic [31:0] rdat,
                            output int stall_cyc);
    int          kind;
    int unsigned off;
    logic [3:0]  ebe;
    logic [31:0] ewd, eaddr, eload, v;
    logic        trap, is_wr, acked;
    int          n;
    kind  = (wc == 4'b0101) ? 1 : (wc == 4'b1010) ? 2 : 0;
    is_wr = wr && !rd;
    off   = (kind == 2) ? a % 4 : (kind == 1) ? ((a % 4) / 2) * 2 : 0;
    trap  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap  = (kind == 1 && (a % 2) != 0) || (kind == 0 && (a % 4) != 0);
`endif
    ebe   = (kind == 2) ? 4'(1 << off) : (kind == 1) ? 4'(3 << off) : 4'hF;
    ewd   = (kind == 2) ? wd[7:0] * 32'h01010101 :
            (kind == 1) ? wd[15:0] * 32'h00010001 : wd;
    eaddr = a - (a % 4);
    v     = rdat >> (8 * off);
    if (kind == 2) begin
      eload = v & 32'hFF;
      if (!zx && eload >= 128) eload = eload - 256;
    end else if (kind == 1) begin
      eload = v & 32'hFFFF;
      if (!zx && eload >= 32768) eload = eload - 65536;
    end else begin
      eload = rdat;
    end
    stall_cyc = 0;

    @(posedge clk); #1;
    mem_read_in = rd; mem_write_in = wr; mem_width_in = wc;
    mem_zero_extend_in = zx; addr_in = a; wdata_in = wd;
    @(negedge clk);
    checks++;
    if (stall_out !== !trap) begin
      errors++; $display("FAIL %s request stall: got %b expected %b", nm, stall_out, !trap);
    end
    if (stall_out === 1'b1) stall_cyc++;
    checks++;
    if (bus_req_out !== 1'b0) begin
      errors++; $display("FAIL %s idle bus_req: got %b expected 0", nm, bus_req_out);
    end

    if (trap) begin
      @(posedge clk); #1;
      mem_read_in = 1'b0; mem_write_in = 1'b0;
      @(negedge clk);
      checks++;
      if ({err_out, done_out, bus_req_out, stall_out} !== 4'b1000) begin
        errors++; $display("FAIL %s trap err/done/req/stall: got %b expected 1000", nm,
                           {err_out, done_out, bus_req_out, stall_out});
      end
      return;
    end

    acked = 1'b0;
    n = 0;
    while (!acked && n < int'(TO)) begin
      @(posedge clk); #1;
      mem_read_in  = 1'b0; mem_write_in = 1'b0;
      mem_width_in = 4'($urandom); addr_in = $urandom; wdata_in = $urandom;
      bus_ack_in   = (n == ack_delay);
      bus_rdata_in = (n == ack_delay) ? rdat : $urandom;
      @(negedge clk);
      checks++;
      if ({bus_req_out, stall_out, done_out, err_out} !== 4'b1100) begin
        errors++; $display("FAIL %s bus req/stall/done/err cycle %0d: got %b expected 1100", nm, n,
                           {bus_req_out, stall_out, done_out, err_out});
      end
      if (stall_out === 1'b1) stall_cyc++;
      checks++;
      if (bus_we_out !== is_wr || bus_addr_out !== eaddr || bus_be_out !== ebe) begin
        errors++; $display("FAIL %s bus we/addr/be cycle %0d: got %b %h %b expected %b %h %b", nm, n,
                           bus_we_out, bus_addr_out, bus_be_out, is_wr, eaddr, ebe);
      end
      if (is_wr) begin
        checks++;
        if (bus_wdata_out !== ewd) begin
          errors++; $display("FAIL %s bus_wdata cycle %0d: got %h expected %h", nm, n, bus_wdata_out, ewd);
        end
      end
      checks++;
      if (rdata_out !== model_rdata) begin
        errors++; $display("FAIL %s rdata hold cycle %0d: got %h expected %h", nm, n, rdata_out, model_rdata);
      end
      acked = (n == ack_delay);
      n++;
    end

    @(posedge clk); #1;
    bus_ack_in = 1'b0;
    @(negedge clk);
    if (acked && rd) model_rdata = eload;
    checks++;
    if ({done_out, err_out} !== {acked, !acked}) begin
      errors++; $display("FAIL %s completion done/err: got %b%b expected %b%b", nm,
                         done_out, err_out, acked, !acked);
    end
    checks++;
    if (rdata_out !== model_rdata) begin
      errors++; $display("FAIL %s rdata_out: got %h expected %h", nm, rdata_out, model_rdata);
    end
    checks++;
    if ({bus_req_out, stall_out, bus_be_out} !== 6'b0) begin
      errors++; $display("FAIL %s post-access req/stall/be: got %b expected 000000", nm,
                         {bus_req_out, stall_out, bus_be_out});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_read_in = 1'b0; mem_write_in = 1'b0; mem_width_in = 4'b0000;
    mem_zero_extend_in = 1'b0; addr_in = '0; wdata_in = '0;
    bus_ack_in = 1'b0; bus_rdata_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_req_out, bus_we_out, done_out, err_out, stall_out, bus_be_out} !== 9'b0 ||
        rdata_out !== 32'h0) begin
      errors++; $display("FAIL reset outputs: got req=%b we=%b done=%b err=%b stall=%b be=%b rdata=%h expected all zero",
                         bus_req_out, bus_we_out, done_out, err_out, stall_out, bus_be_out, rdata_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_rdata = 32'h0;
  endtask

  task automatic test_lw();
    int sc;
    run_access("lw", 1'b1, 1'b0, 4'b0000, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, sc);
    checks++;
    if (sc != 2) begin
      errors++; $display("FAIL lw stall cycles: got %0d expected 2", sc);
    end
    checks++;
    if (rdata_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw rdata literal: got %h expected deadbeef", rdata_out);
    end
  endtask

  task automatic test_byte_loads();
    int sc;
    run_access("lb", 1'b1, 1'b0, 4'b1010, 1'b0, 32'h103, 32'h0, 1, 32'h80FFFFFF, sc);
    checks++;
    if (rdata_out !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb rdata literal: got %h expected ffffff80", rdata_out);
    end
    run_access("lbu", 1'b1, 1'b0, 4'b1010, 1'b1, 32'h103, 32'h0, 0, 32'h80FFFFFF, sc);
    checks++;
    if (rdata_out !== 32'h00000080) begin
      errors++; $display("FAIL lbu rdata literal: got %h expected 00000080", rdata_out);
    end
  endtask

  task automatic test_store_half();
    int sc;
    run_access("sh", 1'b0, 1'b1, 4'b0101, 1'b0, 32'h202, 32'h00001234, 2, 32'h0, sc);
    run_access("lh_sign", 1'b1, 1'b0, 4'b0101, 1'b0, 32'h206, 32'h0, 0, 32'h9ABC1234, sc);
  endtask

  task automatic test_timeout();
    int sc;
    run_access("timeout", 1'b1, 1'b0, 4'b0000, 1'b0, 32'h400, 32'h0, int'(TO), 32'h0, sc);
    checks++;
    if (sc != int'(TO) + 1) begin
      errors++; $display("FAIL timeout stall cycles: got %0d expected %0d", sc, TO + 1);
    end
  endtask

  task automatic test_misalign();
    int sc;
    run_access("lw_misaligned", 1'b1, 1'b0, 4'b0000, 1'b0, 32'h101, 32'h0, 0, 32'h11223344, sc);
    run_access("sh_misaligned", 1'b0, 1'b1, 4'b0101, 1'b0, 32'h203, 32'hA5A5BEEF, 1, 32'h0, sc);
  endtask

  task automatic test_read_write_both();
    int sc;
    run_access("rd_wr_both", 1'b1, 1'b1, 4'b0101, 1'b0, 32'h2, 32'hFFFF0000, 0, 32'h8001FFFF, sc);
    run_access("other_width", 1'b1, 1'b0, 4'b0111, 1'b1, 32'h500, 32'h0, 1, 32'h87654321, sc);
  endtask

  task automatic test_ack_outside_bus();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_ack_in = 1'b1; bus_rdata_in = $urandom;
      @(negedge clk);
      checks++;
      if ({done_out, err_out, bus_req_out, stall_out} !== 4'b0 || rdata_out !== model_rdata) begin
        errors++; $display("FAIL stray ack %0d: got done/err/req/stall=%b rdata=%h expected 0000 %h", i,
                           {done_out, err_out, bus_req_out, stall_out}, rdata_out, model_rdata);
      end
    end
    @(posedge clk); #1;
    bus_ack_in = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    int sc;
    @(posedge clk); #1;
    mem_read_in = 1'b1; mem_width_in = 4'b0000; addr_in = 32'h300;
    @(posedge clk); #1;
    mem_read_in = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_req_out !== 1'b1) begin
      errors++; $display("FAIL rst_mid bus_req before reset: got %b expected 1", bus_req_out);
    end
    @(posedge clk); #1;
    reset = 1'b0; bus_ack_in = 1'b1; bus_rdata_in = 32'hCAFEF00D;
    model_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({bus_req_out, stall_out, done_out, err_out} !== 4'b0 || rdata_out !== 32'h0) begin
      errors++; $display("FAIL rst_mid after reset: got req/stall/done/err=%b rdata=%h expected 0000 0",
                         {bus_req_out, stall_out, done_out, err_out}, rdata_out);
    end
    @(posedge clk); #1;
    bus_ack_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_out, err_out, bus_req_out} !== 3'b0 || rdata_out !== 32'h0) begin
      errors++; $display("FAIL rst_mid late ack: got done/err/req=%b rdata=%h expected 000 0",
                         {done_out, err_out, bus_req_out}, rdata_out);
    end
    run_access("after_reset", 1'b1, 1'b0, 4'b1010, 1'b1, 32'h301, 32'h0, 0, 32'h0000AB00, sc);
  endtask

  task automatic test_random();
    int sc, d;
    logic rd, wr;
    logic [3:0] wc;
    logic [3:0] codes [4];
    codes[0] = 4'b0000; codes[1] = 4'b0101; codes[2] = 4'b1010; codes[3] = 4'b0011;
    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      wc = codes[$urandom_range(0, 3)];
      d  = ($urandom_range(0, 9) == 0) ? int'(TO) : int'($urandom_range(0, 4));
      run_access($sformatf("rand%0d", i), rd, wr, wc, 1'($urandom), $urandom, $urandom, d, $urandom, sc);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_loads();
    test_store_half();
    test_timeout();
    test_misalign();
    test_read_write_both();
    test_ack_outside_bus();
    test_reset_mid_bus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
